// File: rtl/press_pkg.sv
// Shared types for the button press classifier: FSM states, event codes
// and small constant helpers.
package press_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRESS = 2'd1,
    S_GAP   = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EV_NONE   = 2'd0,
    EV_SHORT  = 2'd1,
    EV_LONG   = 2'd2,
    EV_DOUBLE = 2'd3
  } event_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic ev_valid(input event_e ev);
    return (ev != EV_NONE);
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Classifies debounced button activity into short, long and double presses,
// emitting one-cycle registered pulses plus an event code and event counter.
module press_classifier
  import press_pkg::*;
#(
  parameter int LONG_CYC   = 25_000_000,
  parameter int DOUBLE_CYC = 12_500_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_level,
  output logic       o_short,
  output logic       o_long,
  output logic       o_double,
  output logic [1:0] o_code,
  output logic       o_held,
  output logic [7:0] o_count
);

  localparam int CNT_W = $clog2(max_int(LONG_CYC, DOUBLE_CYC));
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             short_q, short_d;
  logic             long_q, long_d;
  logic             double_q, double_d;
  event_e           code_q, code_d;
  logic [7:0]       count_q, count_d;
  event_e           ev_s;

  // Next-state logic; release beats the long threshold, press beats the gap timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_s    = EV_NONE;
    level_d = i_level;
    case (state_q)
      S_IDLE: begin
        if (!level_q) begin
          state_d = S_PRESS;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRESS: begin
        if (level_q) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          ev_s    = EV_LONG;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (!level_q) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          ev_s    = EV_DOUBLE;
        end else if (cnt_q == DOUBLE_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ev_s    = EV_SHORT;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_HOLD: begin
        if (level_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Decode the event into pulses and advance the event counter one cycle later.
  always_comb begin
    short_d  = (ev_s == EV_SHORT);
    long_d   = (ev_s == EV_LONG);
    double_d = (ev_s == EV_DOUBLE);
    code_d   = ev_s;
    if (ev_valid(code_q)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // State, counter, input sample and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      level_q  <= 1'b1;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      code_q   <= EV_NONE;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      code_q   <= code_d;
      count_q  <= count_d;
    end
  end

  assign o_short  = short_q;
  assign o_long   = long_q;
  assign o_double = double_q;
  assign o_code   = code_q;
  assign o_held   = ~level_q;
  assign o_count  = count_q;

endmodule

// File: doc/press_classifier.md
PRESS_CLASSIFIER -- requirements
Module: press_classifier

Interface
REQ-001 SHALL have parameter LONG_CYC, default 25_000_000: number of press cycles (0.5 s at 50 MHz) that qualify a long press; legal range >= 2.
REQ-002 SHALL have parameter DOUBLE_CYC, default 12_500_000: maximum release gap (0.25 s) that still qualifies a double press; legal range >= 2.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock, 50 MHz (CLOCK_50); all logic runs on the rising edge.
REQ-004 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port i_level, input, 1 bit: debounced button level from the debounce stage; 0 = pressed, 1 = released.
REQ-006 SHALL have port o_short, output, 1 bit: one-cycle pulse for a short single press.
REQ-007 SHALL have port o_long, output, 1 bit: one-cycle pulse for a long press.
REQ-008 SHALL have port o_double, output, 1 bit: one-cycle pulse for a double press.
REQ-009 SHALL have port o_code, output, 2 bits: event code, valid only while a pulse is high; 0 = none, 1 = short, 2 = long, 3 = double.
REQ-010 SHALL have port o_held, output, 1 bit: registered pressed level (1 = pressed), for driving an LED.
REQ-011 SHALL have port o_count, output, 8 bits: total classified events; wraps from 255 to 0.

Function
REQ-012 SHALL register i_level once into level_q; the FSM acts only on level_q.
REQ-013 SHALL implement FSM states S_IDLE, S_PRESS, S_GAP and S_HOLD, with a cycle counter cnt sized to clog2(max(LONG_CYC, DOUBLE_CYC)).
REQ-014 SHALL clear cnt on every state transition.
REQ-015 In S_IDLE, level_q = 0 SHALL move the FSM to S_PRESS.
REQ-016 In S_PRESS, cnt SHALL increment each cycle.
  - level_q = 1 moves the FSM to S_GAP.
  - level_q = 0 with cnt == LONG_CYC-1 asserts o_long (code 2) and moves the FSM to S_HOLD.
  - If release and the LONG_CYC-1 threshold occur in the same cycle, release wins: the press is not long.
REQ-017 In S_GAP, cnt SHALL increment each cycle.
  - level_q = 0 asserts o_double (code 3) and moves the FSM to S_HOLD.
  - cnt == DOUBLE_CYC-1 with level_q = 1 asserts o_short (code 1) and moves the FSM to S_IDLE.
  - If a press and the DOUBLE_CYC-1 threshold occur in the same cycle, the press wins: the event is a double.
REQ-018 In S_HOLD, the FSM SHALL wait for level_q = 1, then return to S_IDLE without emitting an event.
REQ-019 All pulse outputs SHALL be registered, high for exactly one cycle, asserted in the same cycle as the state transition, and mutually exclusive.
REQ-020 o_code SHALL be 0 whenever no pulse is high.
REQ-021 o_count SHALL increment by 1 in the cycle after any pulse.
REQ-022 o_held SHALL equal ~level_q.
REQ-023 Latency: a press longer than LONG_CYC SHALL produce o_long exactly LONG_CYC+1 rising edges after the first edge on which i_level = 0 is sampled.

Reset
REQ-024 While i_rst_n = 0, the block SHALL asynchronously force: state = S_IDLE, cnt = 0, level_q = 1, o_short = o_long = o_double = 0, o_code = 0, o_held = 0, o_count = 0.
REQ-025 A reset asserted mid-press or mid-gap SHALL discard the partial event; after release of reset, a button still held SHALL be treated as a new press starting in S_IDLE.

Structure
REQ-026 Package press_pkg SHALL hold the state enum (S_IDLE, S_PRESS, S_GAP, S_HOLD) and the event-code enum (EV_NONE, EV_SHORT, EV_LONG, EV_DOUBLE).
REQ-027 press_classifier SHALL be a single module with no sub-module.
REQ-028 press_classifier SHALL sit between the debounce stage and the LED/button logic in the DE2_115 top.

Verification (LONG_CYC = 8, DOUBLE_CYC = 4)
REQ-029 Press for 3 cycles, then release and hold released for 10 cycles -> exactly one o_short with o_code = 1 and o_count = 1; no other pulse.
REQ-030 Press for 20 cycles -> o_long with o_code = 2, 9 edges after the press is sampled; no event on release; o_held = 1 throughout the press.
REQ-031 Press 2 cycles, release 2 cycles, press again -> o_double with o_code = 3; no o_short afterwards, even if the second press lasts 20 cycles.
REQ-032 Release gap exactly DOUBLE_CYC cycles, then press (the same-cycle boundary case) -> o_double; release gap DOUBLE_CYC+1 cycles -> o_short, and the following press starts a new event.
REQ-033 Generate 256 short presses -> o_count wraps to 0.
REQ-034 Assert reset mid-S_PRESS with the button held -> all outputs are 0 immediately; after reset release, a continued hold produces o_long LONG_CYC+1 edges later.
